// File: rtl/buffered_dataflow_node.sv
// buffered_dataflow_node: joins INPUT_SIZE operands, applies OP, and fans the result out through per-consumer FIFOs.
module buffered_dataflow_node #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    INPUT_SIZE  = 1,
  parameter int    OUTPUT_SIZE = 1,
  parameter int    DEPTH       = 2,
  parameter string OP          = "pass",
  parameter int    IMMEDIATE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [31:0]                       fire_count,
  output logic                              proto_err
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);
  logic [INPUT_SIZE-1:0]             has_q, has_d, req_l_q;
  logic [DATA_WIDTH-1:0]             op_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]             mem_q [OUTPUT_SIZE][DEPTH];
  logic [PW-1:0]                     wp_q [OUTPUT_SIZE];
  logic [PW-1:0]                     rp_q [OUTPUT_SIZE];
  logic [CW-1:0]                     cnt_q [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0]            ack_r_q, pop, full;
  logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout_q;
  logic [31:0]                       fire_count_q;
  logic                              proto_err_q, fire;
  logic [DATA_WIDTH-1:0]             res;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    res = op_q[0];
    for (int i = 1; i < INPUT_SIZE; i++)
      res = OP == "add" ? res + op_q[i] : OP == "sub" ? res - op_q[i] : OP == "mul" ? res * op_q[i] : res;
    res = OP == "addi" ? res + IMM : OP == "subi" ? res - IMM : OP == "muli" ? res * IMM : res;
  end

  // Firing looks only at pre-edge counts, so a same-edge pop never makes room.
  always_comb begin
    pop  = '0;
    full = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      pop[k]  = cnt_q[k] != '0 && req_r[k] && !ack_r_q[k];
      full[k] = cnt_q[k] == CW'(DEPTH);
    end
    fire  = &has_q && !(|full);
    has_d = fire ? '0 : has_q | ack_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      has_q        <= '0;
      req_l_q      <= '0;
      ack_r_q      <= '0;
      dout_q       <= '0;
      fire_count_q <= '0;
      proto_err_q  <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) op_q[i] <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[k][d] <= '0;
      end
    end else begin
      has_q        <= has_d;
      req_l_q      <= ~has_d;
      ack_r_q      <= pop;
      fire_count_q <= fire_count_q + 32'(fire);
      proto_err_q  <= proto_err_q | (|(ack_l & has_q));
      for (int i = 0; i < INPUT_SIZE; i++)
        if (ack_l[i] && !has_q[i]) op_q[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        if (fire) begin
          mem_q[k][wp_q[k]] <= res;
          wp_q[k]           <= nxt(wp_q[k]);
        end
        if (pop[k]) begin
          dout_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem_q[k][rp_q[k]];
          rp_q[k]                            <= nxt(rp_q[k]);
        end
        cnt_q[k] <= cnt_q[k] + CW'(fire) - CW'(pop[k]);
      end
    end
  end

  assign req_l      = req_l_q;
  assign ack_r      = ack_r_q;
  assign dout       = dout_q;
  assign fire_count = fire_count_q;
  assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_buffered_dataflow_node.sv
// tb_buffered_dataflow_node: directed checks of join, arithmetic, fan-out buffering, protocol error and reset.
module tb_buffered_dataflow_node;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [1:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
  logic [63:0] a_din, a_dout;
  logic [31:0] a_fc;
  logic        a_pe;
  buffered_dataflow_node #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(2), .DEPTH(2), .OP("add")) u_a (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r),
    .ack_r(a_ack_r), .dout(a_dout), .fire_count(a_fc), .proto_err(a_pe));

  logic [2:0]  s_req_l, s_ack_l;
  logic [95:0] s_din;
  logic        s_req_r, s_ack_r, s_pe;
  logic [31:0] s_dout, s_fc;
  buffered_dataflow_node #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(2), .OP("sub")) u_s (
    .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din), .req_r(s_req_r),
    .ack_r(s_ack_r), .dout(s_dout), .fire_count(s_fc), .proto_err(s_pe));

  logic       m_req_l, m_ack_l, m_req_r, m_ack_r, m_pe;
  logic [7:0] m_din, m_dout;
  logic [31:0] m_fc;
  buffered_dataflow_node #(.DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2), .OP("muli"), .IMMEDIATE(3)) u_m (
    .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din), .req_r(m_req_r),
    .ack_r(m_ack_r), .dout(m_dout), .fire_count(m_fc), .proto_err(m_pe));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed_a(input logic [31:0] v);
    a_din   = {32'd0, v};
    a_ack_l = 2'b11;
    tick();
    a_ack_l = 2'b00;
    tick();
  endtask

  initial begin
    a_ack_l = '0; a_din = '0; a_req_r = '0;
    s_ack_l = '0; s_din = '0; s_req_r = 1'b0;
    m_ack_l = 1'b0; m_din = '0; m_req_r = 1'b0;
    tick();
    tick();
    chk("rst_req_l", 64'(a_req_l), 64'h0);
    chk("rst_ack_r", 64'(a_ack_r), 64'h0);
    chk("rst_dout", a_dout, 64'h0);
    chk("rst_fc", 64'(a_fc), 64'h0);
    chk("rst_pe", 64'(a_pe), 64'h0);
    rst = 1'b0;
    tick();
    chk("rel_req_l", 64'(a_req_l), 64'h3);
    // add: 5 + 7 with both consumers ready
    a_req_r = 2'b11;
    a_din   = {32'd7, 32'd5};
    a_ack_l = 2'b11;
    tick();
    chk("cap_req_l", 64'(a_req_l), 64'h0);
    a_ack_l = 2'b00;
    tick();
    chk("fire_fc", 64'(a_fc), 64'd1);
    chk("fire_ack_r", 64'(a_ack_r), 64'h0);
    chk("fire_req_l", 64'(a_req_l), 64'h3);
    tick();
    chk("add_ack_r", 64'(a_ack_r), 64'h3);
    chk("add_dout", a_dout, {32'd12, 32'd12});
    tick();
    chk("add_pulse", 64'(a_ack_r), 64'h0);
    chk("add_hold", a_dout, {32'd12, 32'd12});
    // consumer 1 stalled: fills its buffer and blocks the third firing
    a_req_r = 2'b01;
    feed_a(32'd1);
    chk("st_fc1", 64'(a_fc), 64'd2);
    tick();
    chk("st_ack1", 64'(a_ack_r), 64'h1);
    chk("st_d01", 64'(a_dout[31:0]), 64'd1);
    feed_a(32'd2);
    chk("st_fc2", 64'(a_fc), 64'd3);
    tick();
    chk("st_ack2", 64'(a_ack_r), 64'h1);
    chk("st_d02", 64'(a_dout[31:0]), 64'd2);
    feed_a(32'd3);
    chk("st_blk_fc", 64'(a_fc), 64'd3);
    chk("st_blk_req_l", 64'(a_req_l), 64'h0);
    tick();
    tick();
    chk("st_blk_fc2", 64'(a_fc), 64'd3);
    chk("st_blk_ack", 64'(a_ack_r), 64'h0);
    a_req_r = 2'b11;
    tick();
    chk("un_ack", 64'(a_ack_r), 64'h2);
    chk("un_d11", 64'(a_dout[63:32]), 64'd1);
    chk("un_nofire", 64'(a_fc), 64'd3);
    tick();
    chk("un_fc", 64'(a_fc), 64'd4);
    chk("un_gap", 64'(a_ack_r), 64'h0);
    chk("un_req_l", 64'(a_req_l), 64'h3);
    tick();
    chk("un_ack2", 64'(a_ack_r), 64'h3);
    chk("un_d12", 64'(a_dout[63:32]), 64'd2);
    chk("un_d03", 64'(a_dout[31:0]), 64'd3);
    tick();
    tick();
    chk("un_ack3", 64'(a_ack_r), 64'h2);
    chk("un_d13", 64'(a_dout[63:32]), 64'd3);
    tick();
    // duplicate ack on operand 0: second value dropped, error latched
    a_din   = {32'd0, 32'd20};
    a_ack_l = 2'b01;
    tick();
    chk("pe_clean", 64'(a_pe), 64'h0);
    a_din = {32'd0, 32'd99};
    tick();
    chk("pe_set", 64'(a_pe), 64'h1);
    chk("pe_req_l", 64'(a_req_l), 64'h2);
    a_din   = {32'd5, 32'd99};
    a_ack_l = 2'b10;
    tick();
    a_ack_l = 2'b00;
    tick();
    chk("pe_fc", 64'(a_fc), 64'd5);
    tick();
    chk("pe_ack", 64'(a_ack_r), 64'h3);
    chk("pe_dout", a_dout, {32'd25, 32'd25});
    chk("pe_sticky", 64'(a_pe), 64'h1);
    tick();
    // reset with two results buffered
    a_req_r = 2'b00;
    feed_a(32'd8);
    feed_a(32'd9);
    chk("rb_fc", 64'(a_fc), 64'd7);
    rst     = 1'b1;
    a_req_r = 2'b11;
    tick();
    chk("rb_fc0", 64'(a_fc), 64'd0);
    chk("rb_pe0", 64'(a_pe), 64'h0);
    chk("rb_req_l", 64'(a_req_l), 64'h0);
    chk("rb_dout", a_dout, 64'h0);
    rst = 1'b0;
    tick();
    chk("rb_rel_req_l", 64'(a_req_l), 64'h3);
    for (int n = 0; n < 4; n++) begin
      chk("rb_no_ack", 64'(a_ack_r), 64'h0);
      tick();
    end
    // sub with wrap: 10 - 3 - 9
    s_req_r = 1'b1;
    s_din   = {32'd9, 32'd3, 32'd10};
    s_ack_l = 3'b111;
    tick();
    s_ack_l = 3'b000;
    tick();
    chk("sub_fc", 64'(s_fc), 64'd1);
    tick();
    chk("sub_ack", 64'(s_ack_r), 64'h1);
    chk("sub_dout", 64'(s_dout), 64'hFFFF_FFFE);
    // operands arriving on separate cycles: 100 - 30 - 1
    s_din   = {32'd0, 32'd0, 32'd100};
    s_ack_l = 3'b001;
    tick();
    chk("sub_req_l", 64'(s_req_l), 64'h6);
    chk("sub_pulse", 64'(s_ack_r), 64'h0);
    s_din   = {32'd1, 32'd0, 32'd0};
    s_ack_l = 3'b100;
    tick();
    s_din   = {32'd0, 32'd30, 32'd0};
    s_ack_l = 3'b010;
    tick();
    s_ack_l = 3'b000;
    tick();
    chk("sub_fc2", 64'(s_fc), 64'd2);
    tick();
    chk("sub_ack2", 64'(s_ack_r), 64'h1);
    chk("sub_dout2", 64'(s_dout), 64'd69);
    chk("sub_pe", 64'(s_pe), 64'h0);
    // muli 0x60 * 3 truncated to 8 bits
    m_req_r = 1'b1;
    m_din   = 8'h60;
    m_ack_l = 1'b1;
    tick();
    m_ack_l = 1'b0;
    tick();
    tick();
    chk("muli_ack", 64'(m_ack_r), 64'h1);
    chk("muli_dout", 64'(m_dout), 64'h20);
    chk("muli_fc", 64'(m_fc), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
